// File: rtl/strided_collector_if.sv
// Output-FIFO side of the strided collector.
//   fifo_push  collector -> FIFO   push strobe
//   fifo_dat   collector -> FIFO   beat data, lane i at bits [i*DW +: DW]
//   fifo_mask  collector -> FIFO   per-lane valid mask for the beat
//   fifo_full  FIFO -> collector   FIFO cannot accept a push this cycle
interface strided_collector_if #(
  parameter int LANES = 2,
  parameter int DW    = 32
) ();
  logic                  fifo_push;
  logic [LANES*DW-1:0]   fifo_dat;
  logic [LANES-1:0]      fifo_mask;
  logic                  fifo_full;

  modport master (output fifo_push, output fifo_dat, output fifo_mask, input fifo_full);
  modport slave  (input fifo_push, input fifo_dat, input fifo_mask, output fifo_full);
endinterface

// File: rtl/strided_collector.sv
// Drains the M x K systolic-array result matrix into the output FIFO,
// LANES words per beat, in row- or column-major order chosen per job.
// Partial last beats are zero-padded and qualified by fifo_mask.
//
// Ports
//   clk              clock, all logic on posedge
//   nrst             synchronous active-low reset
//   start_i          1-cycle pulse arming a new job (ignored while busy)
//   col_major_i      order select, latched with start: 0 row-major, 1 column-major
//   out_i            result words, element r*K+c at [(r*K+c)*DW +: DW]
//   done_dispatch_i  dispatcher has issued all operands
//   done_i           array computation complete (level or pulse)
//   err_i            array error (level or pulse)
//   fif              FIFO interface (master side)
//   sys_comp_done_o  sticky: done seen in this job
//   sys_comp_err_o   sticky: err seen in this job
//   fill_done_o      sticky: every word has been pushed
//   busy_o           high in WAIT or DRAIN
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, waiting for start
// WAIT  | armed, waiting for done (and done_dispatch) or err
// DRAIN | pushing beats while the FIFO has room
// DONE  | all words pushed, waiting for the next start
// ERR   | job aborted by err, waiting for the next start
module strided_collector #(
  parameter int M     = 4,
  parameter int K     = 4,
  parameter int LANES = 2,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start_i,
  input  logic                 col_major_i,
  input  logic [M*K*DW-1:0]    out_i,
  input  logic                 done_dispatch_i,
  input  logic                 done_i,
  input  logic                 err_i,
  strided_collector_if.master  fif,
  output logic                 sys_comp_done_o,
  output logic                 sys_comp_err_o,
  output logic                 fill_done_o,
  output logic                 busy_o
);

  localparam int MK = M * K;
  localparam int PW = $clog2(MK + LANES) + 1;
  // Order table spans every value ptr+lane can take, so lookups never go out of range.
  localparam int NE = 2 ** PW;
  localparam logic [PW-1:0] MK_P    = PW'(MK);
  localparam logic [PW-1:0] LANES_P = PW'(LANES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            col_major_q, col_major_d;
  logic            comp_done_q, comp_done_d;
  logic            comp_err_q, comp_err_d;
  logic            fill_done_q, fill_done_d;

  logic                push_c;
  logic [PW-1:0]       ptr_nxt;
  logic                last_beat;
  logic [LANES*DW-1:0] dat_c;
  logic [LANES-1:0]    mask_c;

  // Order element e -> source word. The column-major index is a constant per
  // entry, so the only run-time cost is a 2:1 mux per element.
  logic [DW-1:0] ord_word [NE];

  for (genvar e = 0; e < NE; e++) begin : g_ord
    if (e < MK) begin : g_live
      localparam int SRC_C = ((e % M) * K) + (e / M);
      assign ord_word[e] = col_major_q ? out_i[SRC_C*DW +: DW] : out_i[e*DW +: DW];
    end else begin : g_pad
      assign ord_word[e] = '0;
    end
  end

  assign ptr_nxt   = ptr_q + LANES_P;
  assign last_beat = (ptr_nxt >= MK_P);

  always_comb begin
    logic [PW-1:0] e_idx;
    e_idx  = '0;
    dat_c  = '0;
    mask_c = '0;
    if (state_q == S_DRAIN) begin
      for (int i = 0; i < LANES; i++) begin
        e_idx = ptr_q + PW'(i);
        if (e_idx < MK_P) begin
          mask_c[i]          = 1'b1;
          dat_c[i*DW +: DW]  = ord_word[e_idx];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    col_major_d = col_major_q;
    comp_done_d = comp_done_q;
    comp_err_d  = comp_err_q;
    fill_done_d = fill_done_q;
    push_c      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d     = S_WAIT;
          ptr_d       = '0;
          col_major_d = col_major_i;
          comp_done_d = 1'b0;
          comp_err_d  = 1'b0;
          fill_done_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (done_i) comp_done_d = 1'b1;
        if (err_i)  comp_err_d  = 1'b1;
        // Decide on the registered stickies so a same-cycle done+err resolves to ERR.
        if (comp_err_q) begin
          state_d = S_ERR;
        end else if (comp_done_q && done_dispatch_i) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        push_c = ~fif.fifo_full;
        if (done_i) comp_done_d = 1'b1;
        if (push_c) begin
          ptr_d = ptr_nxt;
          if (last_beat) begin
            fill_done_d = 1'b1;
            state_d     = S_DONE;
          end
        end
        // A push in the same cycle still completes; err only redirects the state.
        if (err_i) begin
          comp_err_d = 1'b1;
          state_d    = S_ERR;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      col_major_q <= 1'b0;
      comp_done_q <= 1'b0;
      comp_err_q  <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      col_major_q <= col_major_d;
      comp_done_q <= comp_done_d;
      comp_err_q  <= comp_err_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign fif.fifo_push   = push_c;
  assign fif.fifo_dat    = dat_c;
  assign fif.fifo_mask   = mask_c;

  assign sys_comp_done_o = comp_done_q;
  assign sys_comp_err_o  = comp_err_q;
  assign fill_done_o     = fill_done_q;
  assign busy_o          = (state_q == S_WAIT) || (state_q == S_DRAIN);

endmodule
